// File: rtl/l1cache_req_arb_if.sv
// Requester-side and cache-side signal bundle for the L1 request arbiter.
// The arbiter connects through the slave modport; the requesters and cache model use master.
interface l1cache_req_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_hit;
  logic                      rsp_err;
  logic [ADDR_W-1:0]         c_addr;
  logic [DATA_W-1:0]         c_wdata;
  logic                      c_awvalid;
  logic                      c_wvalid;
  logic                      c_arvalid;
  logic                      c_rvalid;
  logic [DATA_W-1:0]         c_rdata;
  logic                      c_w_hit;
  logic                      c_r_hit;
  logic [1:0]                c_w_resp;
  logic [1:0]                c_r_resp;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
           c_rvalid, c_rdata, c_w_hit, c_r_hit, c_w_resp, c_r_resp,
    output req_ready, rsp_valid, rsp_rdata, rsp_hit, rsp_err,
           c_addr, c_wdata, c_awvalid, c_wvalid, c_arvalid
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
           c_rvalid, c_rdata, c_w_hit, c_r_hit, c_w_resp, c_r_resp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_hit, rsp_err,
           c_addr, c_wdata, c_awvalid, c_wvalid, c_arvalid
  );
endinterface

// File: rtl/l1cache_req_arb.sv
// Round-robin arbiter sharing one single-transaction L1 cache port among NUM_REQ requesters.
// Each transaction runs IDLE -> ISSUE -> WAIT -> RESP, and WAIT ends on completion or timeout.
module l1cache_req_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  l1cache_req_arb_if.slave           bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_d;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_d, grant_d, win, idx;
  logic               found;
  logic               wr_l, wr_d, hit_l, hit_d, err_l, err_d, hit_n, rerr, done;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d, rdata_d;
  logic [NUM_REQ-1:0] ready_d, rspv_d;
  logic               awv_d, wv_d, arv_d, rhit_d, rerr_d;

  logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_a[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_a[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d  = state;
    rr_ptr_d = rr_ptr;
    grant_d  = grant_id;
    wr_d     = wr_l;
    hit_d    = hit_l;
    err_d    = err_l;
    cnt_d    = cnt;
    addr_d   = bus.c_addr;
    wdata_d  = bus.c_wdata;
    rdata_d  = bus.rsp_rdata;
    rhit_d   = bus.rsp_hit;
    rerr_d   = bus.rsp_err;
    ready_d  = '0;
    rspv_d   = '0;
    awv_d    = 1'b0;
    wv_d     = 1'b0;
    arv_d    = 1'b0;
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    hit_n    = hit_l | (wr_l ? bus.c_w_hit : bus.c_r_hit);
    done     = wr_l ? bus.c_w_resp[0] : bus.c_rvalid;
    rerr     = wr_l ? bus.c_w_resp[1] : bus.c_r_resp[1];

    // Search starts just past the last winner so it ends up with lowest priority.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    unique case (state)
      IDLE: begin
        if (found) begin
          grant_d  = win;
          rr_ptr_d = win;
          wr_d     = bus.req_write[win];
          addr_d   = addr_a[win];
          wdata_d  = wdata_a[win];
          ready_d  = NUM_REQ'(1) << win;
          awv_d    = bus.req_write[win];
          wv_d     = bus.req_write[win];
          arv_d    = !bus.req_write[win];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        hit_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        hit_d = hit_n;
        // A completion in the final timeout cycle takes precedence over the timeout.
        if (done) begin
          err_d   = rerr;
          rdata_d = wr_l ? '0 : bus.c_rdata;
          rhit_d  = hit_n;
          rerr_d  = rerr;
          rspv_d  = NUM_REQ'(1) << grant_id;
          state_d = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          rhit_d  = hit_n;
          rerr_d  = 1'b1;
          rspv_d  = NUM_REQ'(1) << grant_id;
          state_d = RESP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      rr_ptr        <= ID_W'(NUM_REQ - 1);
      grant_id      <= '0;
      wr_l          <= 1'b0;
      hit_l         <= 1'b0;
      err_l         <= 1'b0;
      cnt           <= '0;
      busy          <= 1'b0;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.c_addr    <= '0;
      bus.c_wdata   <= '0;
      bus.c_awvalid <= 1'b0;
      bus.c_wvalid  <= 1'b0;
      bus.c_arvalid <= 1'b0;
    end else begin
      state         <= state_d;
      rr_ptr        <= rr_ptr_d;
      grant_id      <= grant_d;
      wr_l          <= wr_d;
      hit_l         <= hit_d;
      err_l         <= err_d;
      cnt           <= cnt_d;
      busy          <= (state_d != IDLE);
      bus.req_ready <= ready_d;
      bus.rsp_valid <= rspv_d;
      bus.rsp_rdata <= rdata_d;
      bus.rsp_hit   <= rhit_d;
      bus.rsp_err   <= rerr_d;
      bus.c_addr    <= addr_d;
      bus.c_wdata   <= wdata_d;
      bus.c_awvalid <= awv_d;
      bus.c_wvalid  <= wv_d;
      bus.c_arvalid <= arv_d;
    end
  end
endmodule

// File: tb/tb_l1cache_req_arb.sv
// Directed bench for l1cache_req_arb: the stimulus acts as both the requesters and the cache,
// and every expected value is hand-derived from the cycle timing of the arbiter.
module tb_l1cache_req_arb;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rstn;
  logic       busy;
  logic [1:0] grant_id;
  int         n_cmp = 0;
  int         n_bad = 0;

  l1cache_req_arb_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  l1cache_req_arb #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {bus.req_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_err,
                          bus.c_awvalid, bus.c_wvalid, bus.c_arvalid, busy, grant_id}, 64'd0);
    check({tag, "_data"}, {bus.c_addr, bus.c_wdata}, 64'd0);
    check({tag, "_rdata"}, bus.rsp_rdata, 64'd0);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [19:0] a, input logic [31:0] d);
    bus.req_write[i]                   = wr;
    bus.req_addr[i*ADDR_W +: ADDR_W]   = a;
    bus.req_wdata[i*DATA_W +: DATA_W]  = d;
    bus.req_valid[i]                   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int unsigned exp_g;
    logic [7:0]  seen;

    rstn          = 1'b0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.c_rvalid  = 1'b0;
    bus.c_rdata   = '0;
    bus.c_w_hit   = 1'b0;
    bus.c_r_hit   = 1'b0;
    bus.c_w_resp  = 2'b00;
    bus.c_r_resp  = 2'b00;

    repeat (3) tick();
    check_zero("reset");
    rstn = 1'b1;
    tick();

    // Single write with hit from requester 1
    set_req(1, 1'b1, 20'h00404, 32'hDEADBEEF);
    tick();
    check("w1_ready", bus.req_ready, 64'h2);
    check("w1_valids", {bus.c_awvalid, bus.c_wvalid, bus.c_arvalid}, 64'b110);
    check("w1_addr", bus.c_addr, 64'h00404);
    check("w1_wdata", bus.c_wdata, 64'hDEADBEEF);
    check("w1_grant", grant_id, 64'd1);
    bus.req_valid = '0;
    tick();
    check("w1_valids_drop", {bus.c_awvalid, bus.c_wvalid, bus.c_arvalid, bus.req_ready}, 64'd0);
    check("w1_busy", busy, 64'd1);
    tick();
    tick();
    bus.c_w_hit = 1'b1;
    tick();
    bus.c_w_hit  = 1'b0;
    bus.c_w_resp = 2'b01;
    check("w1_no_early_rsp", bus.rsp_valid, 64'd0);
    tick();
    bus.c_w_resp = 2'b00;
    check("w1_rsp", bus.rsp_valid, 64'h2);
    check("w1_hit_err", {bus.rsp_hit, bus.rsp_err}, 64'b10);
    tick();
    check("w1_idle", {busy, bus.rsp_valid}, 64'd0);

    // Write miss from requester 3, completing in the first WAIT cycle
    set_req(3, 1'b1, 20'h0ABCD, 32'h12345678);
    tick();
    check("wm_ready", bus.req_ready, 64'h8);
    check("wm_grant", grant_id, 64'd3);
    bus.req_valid = '0;
    tick();
    bus.c_w_resp = 2'b01;
    tick();
    bus.c_w_resp = 2'b00;
    check("wm_rsp", bus.rsp_valid, 64'h8);
    check("wm_hit_err", {bus.rsp_hit, bus.rsp_err}, 64'b00);
    tick();

    // All four requesting after reset; requester 0 re-requests right after its grant
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 20'(32'h1000 * (i + 1)), 32'h0);
    for (int k = 0; k < 5; k++) begin
      exp_g = (k == 4) ? 0 : k;
      cyc = 0;
      while (bus.req_ready == '0 && cyc < 20) begin
        tick();
        cyc++;
      end
      check("rr_ready", bus.req_ready, 64'd1 << exp_g);
      check("rr_grant", grant_id, 64'(exp_g));
      if (k > 0) check("rr_turnaround", 64'(cyc), 64'd2);
      bus.req_valid[exp_g] = 1'b0;
      tick();
      if (k == 0) bus.req_valid[0] = 1'b1;
      bus.c_rvalid = 1'b1;
      bus.c_rdata  = 32'h100 + k;
      tick();
      bus.c_rvalid = 1'b0;
      check("rr_rsp", bus.rsp_valid, 64'd1 << exp_g);
      check("rr_rdata", bus.rsp_rdata, 64'h100 + 64'(k));
    end
    tick();
    check("rr_idle", busy, 64'd0);

    // Read timeout on requester 2; garbage on c_rdata must not leak through
    set_req(2, 1'b0, 20'h12340, 32'h0);
    bus.c_rdata = 32'hFFFFFFFF;
    tick();
    check("to_ready", bus.req_ready, 64'h4);
    check("to_valids", {bus.c_awvalid, bus.c_wvalid, bus.c_arvalid}, 64'b001);
    check("to_addr", bus.c_addr, 64'h12340);
    bus.req_valid = '0;
    repeat (TIMEOUT) tick();
    check("to_not_yet", {bus.rsp_valid, busy}, 64'b00001);
    tick();
    check("to_rsp", bus.rsp_valid, 64'h4);
    check("to_err", bus.rsp_err, 64'd1);
    check("to_rdata", bus.rsp_rdata, 64'd0);
    tick();
    check("to_idle", busy, 64'd0);

    // Read with error response; a completion during ISSUE is ignored
    set_req(1, 1'b0, 20'h00AA0, 32'h0);
    tick();
    check("re_ready", bus.req_ready, 64'h2);
    bus.req_valid = '0;
    bus.c_rvalid  = 1'b1;
    bus.c_rdata   = 32'h11111111;
    tick();
    bus.c_rvalid = 1'b0;
    tick();
    check("re_issue_ignored", bus.rsp_valid, 64'd0);
    bus.c_rvalid = 1'b1;
    bus.c_rdata  = 32'hA5A5A5A5;
    bus.c_r_resp = 2'b10;
    bus.c_r_hit  = 1'b1;
    tick();
    bus.c_rvalid = 1'b0;
    bus.c_r_resp = 2'b00;
    bus.c_r_hit  = 1'b0;
    check("re_rsp", bus.rsp_valid, 64'h2);
    check("re_rdata", bus.rsp_rdata, 64'hA5A5A5A5);
    check("re_hit_err", {bus.rsp_hit, bus.rsp_err}, 64'b11);
    tick();

    // Reset in the middle of a write transaction
    set_req(2, 1'b1, 20'h0F0F0, 32'hCAFEF00D);
    tick();
    check("mr_ready", bus.req_ready, 64'h4);
    bus.req_valid = '0;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check_zero("mr_async");
    tick();
    rstn = 1'b1;
    seen = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen = seen | {bus.rsp_valid, bus.c_awvalid, bus.c_wvalid, bus.c_arvalid, busy};
    end
    check("mr_no_activity", seen, 64'd0);
    set_req(0, 1'b0, 20'h00010, 32'h0);
    set_req(2, 1'b0, 20'h00020, 32'h0);
    tick();
    check("mr_prio0", bus.req_ready, 64'h1);
    check("mr_addr", bus.c_addr, 64'h00010);
    bus.req_valid = '0;
    tick();
    bus.c_rvalid = 1'b1;
    bus.c_rdata  = 32'h0BADCAFE;
    tick();
    bus.c_rvalid = 1'b0;
    check("mr_rsp", bus.rsp_valid, 64'h1);
    check("mr_rdata", bus.rsp_rdata, 64'h0BADCAFE);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
